// File: rtl/mgt_01_mul_arbiter_pkg.sv
// Shared types and defaults for the multiplier arbiter: FSM states,
// requester IDs, operand width and watchdog limit.
package mgt_01_mul_arbiter_pkg;

    localparam int MUL_XLEN        = 32;
    localparam int MUL_WDOG_CYCLES = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } mul_state_e;

    typedef enum logic {
        REQ_INT = 1'b0,
        REQ_FP  = 1'b1
    } req_id_e;

endpackage

// File: rtl/mgt_01_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered record of
// the last accepted requester.
module mgt_01_rr_arbiter2
    import mgt_01_mul_arbiter_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    int_valid_i,
    input  logic    fp_valid_i,
    input  logic    accept_i,
    output req_id_e grant_o
);

    req_id_e last_grant_q;
    req_id_e last_grant_d;

    // A lone requester always wins; on a tie (or when idle) the one not
    // granted last is preferred.
    always_comb begin
        grant_o = (last_grant_q == REQ_INT) ? REQ_FP : REQ_INT;
        if (int_valid_i != fp_valid_i) begin
            grant_o = fp_valid_i ? REQ_FP : REQ_INT;
        end
        last_grant_d = accept_i ? grant_o : last_grant_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= REQ_FP;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mgt_01_mul_arbiter.sv
// Shares one Booth multiplier between the integer unit and the FPU, one
// operation at a time. Define MGT_01_MUL_WDOG_EN to enable the WAIT watchdog.
module mgt_01_mul_arbiter
    import mgt_01_mul_arbiter_pkg::*;
#(
    parameter int XLEN        = MUL_XLEN,
    parameter int WDOG_CYCLES = MUL_WDOG_CYCLES
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              int_req_valid_i,
    output logic              int_req_ready_o,
    input  logic [XLEN-1:0]   int_multiplier_i,
    input  logic [XLEN-1:0]   int_multiplicand_i,
    input  logic              fp_req_valid_i,
    output logic              fp_req_ready_o,
    input  logic [XLEN-1:0]   fp_multiplier_i,
    input  logic [XLEN-1:0]   fp_multiplicand_i,
    output logic              int_resp_valid_o,
    input  logic              int_resp_ready_i,
    output logic              fp_resp_valid_o,
    input  logic              fp_resp_ready_i,
    output logic [2*XLEN-1:0] resp_result_o,
    output logic              mul_start_o,
    output logic [XLEN-1:0]   mul_multiplier_o,
    output logic [XLEN-1:0]   mul_multiplicand_o,
    input  logic [2*XLEN-1:0] mul_result_i,
    input  logic              mul_valid_i,
    output logic              mul_error_o
);

    mul_state_e        state_q, state_d;
    req_id_e           owner_q, owner_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [2*XLEN-1:0] result_q, result_d;
    req_id_e           grant;
    logic              accept;
    logic              owner_resp_ready;
    logic              wdog_expire;

    mgt_01_rr_arbiter2 u_rr (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .int_valid_i (int_req_valid_i),
        .fp_valid_i  (fp_req_valid_i),
        .accept_i    (accept),
        .grant_o     (grant)
    );

    // Ready is gated by reset because the state register sits in IDLE then.
    assign int_req_ready_o  = (state_q == ST_IDLE) && (grant == REQ_INT) && !rst_i;
    assign fp_req_ready_o   = (state_q == ST_IDLE) && (grant == REQ_FP) && !rst_i;
    assign accept           = (state_q == ST_IDLE) &&
                              ((grant == REQ_FP) ? fp_req_valid_i : int_req_valid_i);
    assign owner_resp_ready = (owner_q == REQ_FP) ? fp_resp_ready_i : int_resp_ready_i;

    assign mul_start_o        = (state_q == ST_ISSUE);
    assign mul_multiplier_o   = mplier_q;
    assign mul_multiplicand_o = mcand_q;
    assign int_resp_valid_o   = (state_q == ST_RESPOND) && (owner_q == REQ_INT);
    assign fp_resp_valid_o    = (state_q == ST_RESPOND) && (owner_q == REQ_FP);
    assign resp_result_o      = (state_q == ST_RESPOND) ? result_q : '0;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    owner_d  = grant;
                    mplier_d = (grant == REQ_FP) ? fp_multiplier_i : int_multiplier_i;
                    mcand_d  = (grant == REQ_FP) ? fp_multiplicand_i : int_multiplicand_i;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // A real completion beats a watchdog expiry in the same cycle.
                if (mul_valid_i) begin
                    result_d = mul_result_i;
                    state_d  = ST_RESPOND;
                end else if (wdog_expire) begin
                    result_d = '0;
                    state_d  = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (owner_resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            owner_q  <= REQ_INT;
            mplier_q <= '0;
            mcand_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            result_q <= result_d;
        end
    end

`ifdef MGT_01_MUL_WDOG_EN
    localparam int                WDOG_W    = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              err_q, err_d;

    // wdog_q counts WAIT cycles already spent; expiry fires on the last one.
    assign wdog_expire = (state_q == ST_WAIT) && (wdog_q == WDOG_LAST);
    assign mul_error_o = (state_q == ST_RESPOND) && err_q;

    always_comb begin
        wdog_d = '0;
        err_d  = err_q;
        if ((state_q == ST_WAIT) && (state_d == ST_WAIT)) begin
            wdog_d = wdog_q + 1'b1;
        end
        if (wdog_expire && !mul_valid_i) begin
            err_d = 1'b1;
        end else if (state_q == ST_IDLE) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_CYCLES;
    assign wdog_expire = 1'b0;
    assign mul_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_mgt_01_mul_arbiter.sv
// Directed bench for mgt_01_mul_arbiter with a fixed-latency multiplier model.
// Watchdog scenario is exercised only when MGT_01_MUL_WDOG_EN is defined.
module tb_mgt_01_mul_arbiter;

    logic        clk_i;
    logic        rst_i;
    logic        int_req_valid_i, int_req_ready_o;
    logic [31:0] int_multiplier_i, int_multiplicand_i;
    logic        fp_req_valid_i, fp_req_ready_o;
    logic [31:0] fp_multiplier_i, fp_multiplicand_i;
    logic        int_resp_valid_o, int_resp_ready_i;
    logic        fp_resp_valid_o, fp_resp_ready_i;
    logic [63:0] resp_result_o;
    logic        mul_start_o;
    logic [31:0] mul_multiplier_o, mul_multiplicand_o;
    logic [63:0] mul_result_i;
    logic        mul_valid_i;
    logic        mul_error_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    bit stray;
    bit model_en;
    int mul_lat;

    mgt_01_mul_arbiter dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .int_req_valid_i    (int_req_valid_i),
        .int_req_ready_o    (int_req_ready_o),
        .int_multiplier_i   (int_multiplier_i),
        .int_multiplicand_i (int_multiplicand_i),
        .fp_req_valid_i     (fp_req_valid_i),
        .fp_req_ready_o     (fp_req_ready_o),
        .fp_multiplier_i    (fp_multiplier_i),
        .fp_multiplicand_i  (fp_multiplicand_i),
        .int_resp_valid_o   (int_resp_valid_o),
        .int_resp_ready_i   (int_resp_ready_i),
        .fp_resp_valid_o    (fp_resp_valid_o),
        .fp_resp_ready_i    (fp_resp_ready_i),
        .resp_result_o      (resp_result_o),
        .mul_start_o        (mul_start_o),
        .mul_multiplier_o   (mul_multiplier_o),
        .mul_multiplicand_o (mul_multiplicand_o),
        .mul_result_i       (mul_result_i),
        .mul_valid_i        (mul_valid_i),
        .mul_error_o        (mul_error_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Multiplier model: mul_valid_i pulses mul_lat cycles after the start pulse.
    initial begin
        int pend;
        logic signed [63:0] a, b, prod;
        pend = 0;
        prod = '0;
        mul_valid_i  = 1'b0;
        mul_result_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            mul_valid_i = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mul_valid_i  = 1'b1;
                    mul_result_i = prod;
                end
            end else if (mul_start_o && model_en) begin
                a    = $signed(mul_multiplier_o);
                b    = $signed(mul_multiplicand_o);
                prod = a * b;
                pend = mul_lat;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for the given response; flags any response on the other port.
    task automatic wait_resp(input bit is_fp, output int n);
        n = 0;
        while (!(is_fp ? fp_resp_valid_o : int_resp_valid_o) && n < 200) begin
            tick();
            n++;
            if (is_fp ? int_resp_valid_o : fp_resp_valid_o) stray = 1'b1;
        end
    endtask

    initial begin
        rst_i = 1'b0;
        int_req_valid_i = 1'b0; fp_req_valid_i = 1'b0;
        int_multiplier_i = '0; int_multiplicand_i = '0;
        fp_multiplier_i = '0; fp_multiplicand_i = '0;
        int_resp_ready_i = 1'b0; fp_resp_ready_i = 1'b0;
        model_en = 1'b1; mul_lat = 3; stray = 1'b0;

        #2 rst_i = 1'b1;
        #1;
        check("reset_req_ready", {int_req_ready_o, fp_req_ready_o}, 0);
        check("reset_resp_flags", {int_resp_valid_o, fp_resp_valid_o, mul_start_o, mul_error_o}, 0);
        check("reset_result", resp_result_o, 0);
        check("reset_mul_ops", {mul_multiplier_o, mul_multiplicand_o}, 0);
        tick(); tick();
        rst_i = 1'b0;
        #1;
        check("idle_pref_int", {int_req_ready_o, fp_req_ready_o}, 2'b10);

        // Tie after reset: INT first, FP next
        int_multiplier_i = 32'd7; int_multiplicand_i = 32'd6;
        fp_multiplier_i = 32'hFFFF_FFFC; fp_multiplicand_i = 32'hFFFF_FFF7;
        int_req_valid_i = 1'b1; fp_req_valid_i = 1'b1;
        #1;
        check("tie_grant_int", {int_req_ready_o, fp_req_ready_o}, 2'b10);
        tick();
        int_req_valid_i = 1'b0;
        check("issue_start", mul_start_o, 1'b1);
        check("issue_ops_int", {mul_multiplier_o, mul_multiplicand_o}, {32'd7, 32'd6});
        check("issue_no_ready", {int_req_ready_o, fp_req_ready_o}, 2'b00);
        tick();
        check("start_one_cycle", mul_start_o, 1'b0);
        wait_resp(1'b0, cyc);
        check("tie_int_latency", cyc + 2, 5);
        check("tie_int_result", resp_result_o, 64'd42);
        int_resp_ready_i = 1'b1;
        tick();
        int_resp_ready_i = 1'b0;
        check("alt_fp_ready", {int_req_ready_o, fp_req_ready_o}, 2'b01);
        tick();
        fp_req_valid_i = 1'b0;
        check("issue_ops_fp", {mul_multiplier_o, mul_multiplicand_o}, {32'hFFFF_FFFC, 32'hFFFF_FFF7});
        wait_resp(1'b1, cyc);
        check("fp_latency", cyc + 1, 5);
        check("fp_result", {mul_error_o, resp_result_o}, {1'b0, 64'd36});

        // FP response back-pressured for 5 cycles while both request again
        int_multiplier_i = 32'd3; int_multiplicand_i = 32'hFFFF_FFFB;
        int_req_valid_i = 1'b1; fp_req_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_stable", {fp_resp_valid_o, int_resp_valid_o, int_req_ready_o,
                                  fp_req_ready_o, resp_result_o}, {4'b1000, 64'd36});
        end
        fp_resp_ready_i = 1'b1;
        tick();
        fp_resp_ready_i = 1'b0;
        check("alt_int_ready", {int_req_ready_o, fp_req_ready_o}, 2'b10);
        check("idle_result_zero", {fp_resp_valid_o, resp_result_o}, 0);

        // 3 x -5 with a 16-cycle multiplier
        mul_lat = 16;
        tick();
        int_req_valid_i = 1'b0; fp_req_valid_i = 1'b0;
        check("issue_ops_neg", {mul_multiplier_o, mul_multiplicand_o}, {32'd3, 32'hFFFF_FFFB});
        stray = 1'b0;
        wait_resp(1'b0, cyc);
        check("latency_18", cyc + 1, 18);
        check("no_fp_resp", stray, 1'b0);
        check("neg_result", resp_result_o, 64'hFFFF_FFFF_FFFF_FFF1);
        int_resp_ready_i = 1'b1;
        tick();
        int_resp_ready_i = 1'b0;
        check("after_resp_idle", {int_resp_valid_o, resp_result_o}, 0);

        // Reset in the middle of WAIT; the late completion must be ignored
        mul_lat = 10;
        int_multiplier_i = 32'd2; int_multiplicand_i = 32'd9;
        int_req_valid_i = 1'b1;
        tick();
        int_req_valid_i = 1'b0;
        tick(); tick(); tick();
        rst_i = 1'b1;
        #1;
        check("rst_mid_flags", {int_req_ready_o, fp_req_ready_o, int_resp_valid_o,
                                fp_resp_valid_o, mul_start_o, mul_error_o}, 0);
        check("rst_mid_data", {resp_result_o, mul_multiplier_o, mul_multiplicand_o}, 0);
        tick(); tick();
        rst_i = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (int_resp_valid_o || fp_resp_valid_o) stray = 1'b1;
        end
        check("late_valid_ignored", stray, 1'b0);
        check("rst_idle_ready", {int_req_ready_o, fp_req_ready_o}, 2'b10);

        // Normal operation after reset
        mul_lat = 2;
        fp_multiplier_i = 32'd5; fp_multiplicand_i = 32'd5;
        fp_req_valid_i = 1'b1;
        #1;
        check("post_rst_fp_ready", {int_req_ready_o, fp_req_ready_o}, 2'b01);
        tick();
        fp_req_valid_i = 1'b0;
        wait_resp(1'b1, cyc);
        check("post_rst_latency", cyc + 1, 4);
        check("post_rst_result", {mul_error_o, resp_result_o}, {1'b0, 64'd25});
        fp_resp_ready_i = 1'b1;
        tick();
        fp_resp_ready_i = 1'b0;

`ifdef MGT_01_MUL_WDOG_EN
        // Multiplier never completes: watchdog forces an error response
        model_en = 1'b0;
        int_multiplier_i = 32'd1; int_multiplicand_i = 32'd1;
        int_req_valid_i = 1'b1;
        tick();
        int_req_valid_i = 1'b0;
        wait_resp(1'b0, cyc);
        check("wdog_latency", cyc + 1, 26);
        check("wdog_resp", {mul_error_o, resp_result_o}, {1'b1, 64'd0});
        int_resp_ready_i = 1'b1;
        tick();
        int_resp_ready_i = 1'b0;
        check("wdog_err_clear", {mul_error_o, int_resp_valid_o}, 2'b00);
        model_en = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
